// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the stream writer: response codes,
// master FSM states and the FIFO level width helper.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      RESP
   } state_e;

   // Width needed to hold 0..depth inclusive (clog2(depth) + 1).
   function automatic int unsigned level_w(input int unsigned depth);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(depth)) w = i + 1;
      end
      return w + 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with asynchronous reset; push is ignored when full,
// pop is ignored when empty.
module sync_fifo
   import axi_lite_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic [WIDTH-1:0]          pop_data,
   output logic                      full,
   output logic                      empty,
   output logic [level_w(DEPTH)-1:0] level
);

   localparam int unsigned LVL_W = level_w(DEPTH);
   localparam int unsigned PTR_W = LVL_W - 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (level_q == LVL_W'(DEPTH));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: only entries below level are ever read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/axi_lite_stream_writer.sv
// AXI4-Lite write master: buffers stream words and writes each one to a
// circular address window, one outstanding transaction at a time.
module axi_lite_stream_writer
   import axi_lite_pkg::*;
#(
   parameter int unsigned           DATA_W       = 64,
   parameter int unsigned           ADDR_W       = 32,
   parameter int unsigned           FIFO_DEPTH   = 8,
   parameter logic [ADDR_W-1:0]     BASE_ADDR    = '0,
   parameter int unsigned           WINDOW_BYTES = 4096
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [ADDR_W-1:0]              m_awaddr,
   output logic                           m_awvalid,
   input  logic                           m_awready,
   output logic [DATA_W-1:0]              m_wdata,
   output logic [DATA_W/8-1:0]            m_wstrb,
   output logic                           m_wvalid,
   input  logic                           m_wready,
   input  logic                           m_bvalid,
   input  logic [1:0]                     m_bresp,
   output logic                           m_bready,
   input  logic                           err_clear,
   output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
   output logic [31:0]                    wr_count,
   output logic [15:0]                    err_count,
   output logic [1:0]                     last_err_resp
);

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
   localparam logic [ADDR_W-1:0] WRAP_ADDR = BASE_ADDR + ADDR_W'(WINDOW_BYTES);

   state_e            state_q, state_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [31:0]       wr_count_q, wr_count_d;
   logic [15:0]       err_count_q, err_count_d;
   logic [1:0]        last_err_q, last_err_d;
   logic [ADDR_W-1:0] addr_step;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_data;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && !fifo_full;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      next_addr_d = next_addr_q;
      wr_count_d  = wr_count_q;
      err_count_d = err_count_q;
      last_err_d  = last_err_q;
      fifo_pop    = 1'b0;
      addr_step   = next_addr_q + ADDR_STEP;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               wdata_d   = fifo_data;
               awaddr_d  = next_addr_q;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (m_awready) awvalid_d = 1'b0;
            if (m_wready)  wvalid_d  = 1'b0;
            // Both channels done, whether now or on an earlier edge.
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (m_bvalid) begin
               bready_d    = 1'b0;
               state_d     = IDLE;
               wr_count_d  = wr_count_q + 32'd1;
               next_addr_d = (addr_step == WRAP_ADDR) ? BASE_ADDR : addr_step;
               if (m_bresp != RESP_OKAY) begin
                  if (err_count_q != '1) err_count_d = err_count_q + 16'd1;
                  last_err_d = m_bresp;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (err_clear) begin
         err_count_d = '0;
         last_err_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         awaddr_q    <= BASE_ADDR;
         wdata_q     <= '0;
         next_addr_q <= BASE_ADDR;
         wr_count_q  <= '0;
         err_count_q <= '0;
         last_err_q  <= '0;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         next_addr_q <= next_addr_d;
         wr_count_q  <= wr_count_d;
         err_count_q <= err_count_d;
         last_err_q  <= last_err_d;
      end
   end

   assign m_awaddr      = awaddr_q;
   assign m_awvalid     = awvalid_q;
   assign m_wdata       = wdata_q;
   assign m_wstrb       = '1;
   assign m_wvalid      = wvalid_q;
   assign m_bready      = bready_q;
   assign wr_count      = wr_count_q;
   assign err_count     = err_count_q;
   assign last_err_resp = last_err_q;

endmodule

// File: tb/tb_axi_lite_stream_writer.sv
// Bench for axi_lite_stream_writer: transaction-level model plus directed
// scenarios with literal expectations (BASE 0x1000, 32-byte window).
module tb_axi_lite_stream_writer;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int unsigned WIN  = 32;
   localparam int unsigned DEP  = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready;
   logic [63:0] m_wdata;
   logic [7:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready;
   logic        m_bvalid;
   logic [1:0]  m_bresp;
   logic        m_bready;
   logic        err_clear;
   logic [3:0]  fifo_level;
   logic [31:0] wr_count;
   logic [15:0] err_count;
   logic [1:0]  last_err_resp;

   always #5 clk = ~clk;

   axi_lite_stream_writer #(
      .DATA_W       (64),
      .ADDR_W       (32),
      .FIFO_DEPTH   (DEP),
      .BASE_ADDR    (BASE),
      .WINDOW_BYTES (WIN)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .m_awaddr      (m_awaddr),
      .m_awvalid     (m_awvalid),
      .m_awready     (m_awready),
      .m_wdata       (m_wdata),
      .m_wstrb       (m_wstrb),
      .m_wvalid      (m_wvalid),
      .m_wready      (m_wready),
      .m_bvalid      (m_bvalid),
      .m_bresp       (m_bresp),
      .m_bready      (m_bready),
      .err_clear     (err_clear),
      .fifo_level    (fifo_level),
      .wr_count      (wr_count),
      .err_count     (err_count),
      .last_err_resp (last_err_resp)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: a word queue, one outstanding write with
   // per-channel done flags, and completion/error tallies.
   logic [63:0] mq[$];
   logic [31:0] aw_log[$];
   logic [63:0] w_log[$];
   bit          busy, aw_done, w_done;
   logic [63:0] cur_data;
   logic [31:0] cur_addr;
   int unsigned n_done;
   logic [15:0] m_err;
   logic [1:0]  m_last;

   always @(posedge clk or posedge reset) begin
      bit acc;
      if (reset) begin
         mq.delete();
         busy    = 1'b0;
         aw_done = 1'b0;
         w_done  = 1'b0;
         n_done  = 0;
         m_err   = '0;
         m_last  = '0;
      end else begin
         acc = in_valid && (mq.size() < DEP);
         if (busy) begin
            if (aw_done && w_done) begin
               if (m_bvalid) begin
                  busy = 1'b0;
                  n_done++;
                  if (m_bresp != 2'b00) begin
                     if (m_err != 16'hFFFF) m_err++;
                     m_last = m_bresp;
                  end
               end
            end else begin
               if (!aw_done && m_awready) begin
                  aw_done = 1'b1;
                  aw_log.push_back(m_awaddr);
               end
               if (!w_done && m_wready) begin
                  w_done = 1'b1;
                  w_log.push_back(m_wdata);
               end
            end
         end else if (mq.size() != 0) begin
            cur_data = mq.pop_front();
            cur_addr = BASE + 32'((n_done * 8) % WIN);
            busy     = 1'b1;
            aw_done  = 1'b0;
            w_done   = 1'b0;
         end
         if (acc) mq.push_back(in_data);
         if (err_clear) begin
            m_err  = '0;
            m_last = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_awvalid", 64'(m_awvalid), 64'd0);
         chk("rst_wvalid", 64'(m_wvalid), 64'd0);
         chk("rst_bready", 64'(m_bready), 64'd0);
         chk("rst_awaddr", 64'(m_awaddr), 64'(BASE));
         chk("rst_wdata", m_wdata, 64'd0);
         chk("rst_level", 64'(fifo_level), 64'd0);
         chk("rst_in_ready", 64'(in_ready), 64'd1);
         chk("rst_wr_count", 64'(wr_count), 64'd0);
         chk("rst_err_count", 64'(err_count), 64'd0);
         chk("rst_last_err", 64'(last_err_resp), 64'd0);
      end else begin
         chk("awvalid", 64'(m_awvalid), 64'(busy && !aw_done));
         chk("wvalid", 64'(m_wvalid), 64'(busy && !w_done));
         chk("bready", 64'(m_bready), 64'(busy && aw_done && w_done));
         if (busy && !aw_done) chk("awaddr", 64'(m_awaddr), 64'(cur_addr));
         if (busy && !w_done) chk("wdata", m_wdata, cur_data);
         chk("wstrb", 64'(m_wstrb), 64'hFF);
         chk("in_ready", 64'(in_ready), 64'(mq.size() < DEP));
         chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
         chk("wr_count", 64'(wr_count), 64'(n_done));
         chk("err_count", 64'(err_count), 64'(m_err));
         chk("last_err", 64'(last_err_resp), 64'(m_last));
      end
   end

   task automatic push(input logic [63:0] d);
      int unsigned n;
      n        = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: in_ready %0d expected 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while ((busy || mq.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (busy || mq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: pending %0d expected 0", mq.size() + int'(busy));
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      aw_log.delete();
      w_log.delete();
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   logic [31:0] t2_addr [5];
   logic [1:0]  t5_resp [4];

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      m_bvalid  = 1'b1;
      m_bresp   = 2'b00;
      err_clear = 1'b0;
      t2_addr   = '{32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h1000};
      t5_resp   = '{2'b00, 2'b10, 2'b11, 2'b00};
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);

      // Single write with an always-ready slave, then the next address.
      push(64'h0123_4567_89AB_CDEF);
      wait_idle();
      chk("t1_wr_count", 64'(wr_count), 64'd1);
      chk("t1_awaddr", 64'(aw_log[0]), 64'h1000);
      chk("t1_wdata", w_log[0], 64'h0123_4567_89AB_CDEF);
      push(64'h1111_2222_3333_4444);
      wait_idle();
      chk("t1_next_addr", 64'(aw_log[1]), 64'h1008);

      // Five writes across the 32-byte window wrap.
      do_reset();
      for (int i = 0; i < 5; i++) push(64'hA000 + 64'(i));
      wait_idle();
      chk("t2_wr_count", 64'(wr_count), 64'd5);
      for (int i = 0; i < 5; i++) chk("t2_addr", 64'(aw_log[i]), 64'(t2_addr[i]));

      // Split handshakes in both orders.
      do_reset();
      m_awready = 1'b0;
      push(64'hDEAD_BEEF_0000_0001);
      repeat (3) @(negedge clk);
      chk("t3a_awvalid", 64'(m_awvalid), 64'd1);
      chk("t3a_wvalid", 64'(m_wvalid), 64'd0);
      m_awready = 1'b1;
      wait_idle();
      m_wready = 1'b0;
      push(64'hDEAD_BEEF_0000_0002);
      repeat (3) @(negedge clk);
      chk("t3b_awvalid", 64'(m_awvalid), 64'd0);
      chk("t3b_wvalid", 64'(m_wvalid), 64'd1);
      m_wready = 1'b1;
      wait_idle();
      chk("t3_wr_count", 64'(wr_count), 64'd2);
      chk("t3_w0", w_log[0], 64'hDEAD_BEEF_0000_0001);
      chk("t3_w1", w_log[1], 64'hDEAD_BEEF_0000_0002);

      // Stalled slave fills the FIFO; release drains all in order.
      do_reset();
      m_awready = 1'b0;
      m_wready  = 1'b0;
      for (int i = 1; i <= 9; i++) push(64'hC000 + 64'(i));
      in_data  = 64'hC00A;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("t4_in_ready", 64'(in_ready), 64'd0);
      chk("t4_level", 64'(fifo_level), 64'd8);
      in_valid  = 1'b0;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      wait_idle();
      chk("t4_wr_count", 64'(wr_count), 64'd9);
      chk("t4_first", w_log[0], 64'hC001);
      chk("t4_last", w_log[8], 64'hC009);

      // Error responses, clear, and clear winning over a same-cycle error.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         m_bresp = t5_resp[i];
         push(64'hE000 + 64'(i));
         wait_idle();
      end
      chk("t5_err_count", 64'(err_count), 64'd2);
      chk("t5_last_err", 64'(last_err_resp), 64'd3);
      chk("t5_wr_count", 64'(wr_count), 64'd4);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("t5_clr_count", 64'(err_count), 64'd0);
      chk("t5_clr_last", 64'(last_err_resp), 64'd0);
      m_bresp   = 2'b10;
      err_clear = 1'b1;
      push(64'hE004);
      wait_idle();
      err_clear = 1'b0;
      chk("t5_prio_count", 64'(err_count), 64'd0);
      m_bresp = 2'b01;
      push(64'hE005);
      wait_idle();
      m_bresp = 2'b00;
      chk("t5_exokay_count", 64'(err_count), 64'd1);
      chk("t5_exokay_last", 64'(last_err_resp), 64'd1);

      // Reset mid-transaction with queued words.
      do_reset();
      m_awready = 1'b0;
      m_wready  = 1'b0;
      for (int i = 0; i < 5; i++) push(64'hF000 + 64'(i));
      chk("t6_level", 64'(fifo_level), 64'd4);
      #2 reset = 1'b1;
      aw_log.delete();
      w_log.delete();
      #1;
      chk("t6_awvalid", 64'(m_awvalid), 64'd0);
      chk("t6_wvalid", 64'(m_wvalid), 64'd0);
      chk("t6_bready", 64'(m_bready), 64'd0);
      chk("t6_level_rst", 64'(fifo_level), 64'd0);
      m_awready = 1'b1;
      m_wready  = 1'b1;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      push(64'hF0F0);
      wait_idle();
      chk("t6_addr", 64'(aw_log[0]), 64'h1000);
      chk("t6_wr_count", 64'(wr_count), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_lite_stream_writer.md
Name: axi_lite_stream_writer

Overview:
Parametrised AXI4-Lite write master for the QAM-16 output path. It accepts symbol words over a ready/valid stream into an internal FIFO and issues one single-beat AXI4-Lite write per word to a circular address window. AW and W are handshaked independently. BRESP errors are counted and reported. It sits between the modulator's combined output and the interconnect slave port.

Parameters:
DATA_W, 64, data bus width in bits; multiple of 8, one of 32/64.
ADDR_W, 32, AXI address width.
FIFO_DEPTH, 8, input buffer entries; power of 2, >= 2.
BASE_ADDR, 0, first write address; aligned to DATA_W/8.
WINDOW_BYTES, 4096, window size; power of 2, multiple of DATA_W/8; address wraps to BASE_ADDR.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_data  in  DATA_W  word to write
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept; equals !full (combinational from registered level)
m_awaddr  out  ADDR_W  write address
m_awvalid  out  1  address valid
m_awready  in  1  slave accepts address
m_wdata  out  DATA_W  write data
m_wstrb  out  DATA_W/8  byte strobes; always all ones
m_wvalid  out  1  data valid
m_wready  in  1  slave accepts data
m_bvalid  in  1  response valid
m_bresp  in  2  response code
m_bready  out  1  master accepts response
err_clear  in  1  synchronous clear of err_count and last_err_resp
fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
wr_count  out  32  completed writes; wraps at 2^32
err_count  out  16  non-OKAY responses; saturates at 16'hFFFF
last_err_resp  out  2  BRESP of the most recent error

Behaviour:
- Reset (async, active-high): FSM goes to IDLE. m_awvalid, m_wvalid and m_bready = 0. m_awaddr = BASE_ADDR, m_wdata = 0, m_wstrb = all ones. FIFO is emptied (fifo_level = 0, in_ready = 1). Next address = BASE_ADDR. All counters and last_err_resp = 0.
- Input: a word is pushed on a clock edge when in_valid && in_ready. A push is never possible while full. There is no bypass; a word always passes through the FIFO.
- FSM states: IDLE, SEND, RESP.
- IDLE: if the FIFO is non-empty, pop the head, load m_wdata, load m_awaddr with the next address, set m_awvalid = m_wvalid = 1, go to SEND. A word pushed at edge N into an empty FIFO is popped at edge N+1, and valids are high after edge N+1.
- SEND:
  - m_awvalid drops on the edge where m_awready is high; m_wvalid drops on the edge where m_wready is high. The two handshakes may occur in the same cycle or in either order.
  - m_awaddr and m_wdata hold stable while their valid is high.
  - When both handshakes have completed (including in the same cycle), assert m_bready = 1 and go to RESP.
- RESP: on the edge with m_bvalid && m_bready:
  - m_bready drops and the FSM goes to IDLE.
  - wr_count increments.
  - The next address advances by DATA_W/8. If the result equals BASE_ADDR+WINDOW_BYTES, it becomes BASE_ADDR.
  - If m_bresp != 2'b00, err_count saturating-increments and last_err_resp is set to m_bresp.
  - The address advances regardless of the response code.
- There is at most one outstanding transaction. Back-to-back throughput is at most one write per 3 cycles (IDLE, SEND, RESP).
- The FIFO may push while the FSM pops in the same cycle; fifo_level stays unchanged in that case.
- err_clear has priority over a same-cycle error increment: the result is 0.
- Reset mid-transaction abandons the transaction with no completion and no count. Recovery of the slave is system-level.

Decomposition:
- Package axi_lite_pkg holds:
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the FSM state enum (IDLE, SEND, RESP);
  - the clog2-based width helper.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH): synchronous FIFO with async reset, push, pop, full, empty, level outputs.

Test Plan:
1. Defaults with the slave always ready. Push 0x0123_4567_89AB_CDEF → AW 0x0 and W with that data, wstrb 0xFF, bready; wr_count = 1; next address 0x8.
2. WINDOW_BYTES = 32, 5 words pushed → addresses 0x0, 0x8, 0x10, 0x18, 0x0; wr_count = 5.
3. Split handshakes: hold awready low 3 cycles while wready is high, then the reverse on the next write → awvalid/wvalid drop independently, one write each, data unchanged.
4. FIFO_DEPTH = 8, slave stalled (awready = wready = 0), push 10 words → 1 word in SEND plus 8 queued; in_ready low; release the slave → all 9 written in order.
5. BRESP = 2'b10 on write 2 and 2'b11 on write 3 → err_count = 2 and last_err_resp = 2'b11; err_clear pulse → both 0.
6. Assert reset while in SEND with 4 words queued → valids and bready 0 immediately; fifo_level 0; after release, the next write goes to BASE_ADDR.
